// File: rtl/ps2_music_commands.sv
// PS/2 keyboard receiver and transport-command decoder.
// Turns make codes into forward/pause levels and a restart pulse.
module ps2_music_commands #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       kybrd_forward,
  output logic       kybrd_pause,
  output logic       kybrd_restart,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_nx;

  logic                  clk_s1, clk_s2;
  logic                  dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_lvl;
  logic                  all0, all1, fall;

  logic [2:0]            bit_cnt;
  logic [7:0]            sh;
  logic                  par;
  logic [TW-1:0]         to_cnt;
  logic                  to_hit;
  logic                  good;

  logic                  start_en, shift_en, par_en, stop_en, cnt_clr;

  logic                  brk, ext, r_held;

  assign all0   = ~|filt_sr;
  assign all1   = &filt_sr;
  assign fall   = filt_lvl & all0;
  assign to_hit = (state != IDLE) && !fall &&
                  (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign good   = (^{sh, par}) & dat_s2;

  // Two-flop synchronisers and the clock glitch filter.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_sr  <= '1;
      filt_lvl <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      dat_s1  <= ps2_data;
      dat_s2  <= dat_s1;
      filt_sr <= {filt_sr[FILTER_LEN-2:0], clk_s2};
      if (all0)
        filt_lvl <= 1'b0;
      else if (all1)
        filt_lvl <= 1'b1;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Frame FSM next-state logic; a timeout aborts to IDLE.
  always_comb begin
    state_nx = state;
    if (to_hit) begin
      state_nx = IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE:    if (!dat_s2) state_nx = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
        PARITY:  state_nx = STOP;
        STOP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Frame FSM datapath strobes.
  always_comb begin
    start_en = fall && (state == IDLE) && !dat_s2;
    shift_en = fall && (state == DATA);
    par_en   = fall && (state == PARITY);
    stop_en  = fall && (state == STOP);
    cnt_clr  = fall || (state == IDLE);
  end

  // Bit shifter, parity capture, timeout counter and frame results.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      sh          <= '0;
      par         <= 1'b0;
      to_cnt      <= '0;
      scan_code   <= '0;
      scan_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      scan_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (cnt_clr)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;
      if (start_en)
        bit_cnt <= '0;
      if (shift_en) begin
        sh      <= {dat_s2, sh[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_en)
        par <= dat_s2;
      if (stop_en) begin
        if (good) begin
          scan_code  <= sh;
          scan_valid <= 1'b1;
        end else begin
          frame_error <= 1'b1;
        end
      end
      if (to_hit)
        frame_error <= 1'b1;
    end
  end

  // Command decoder: prefix tracking and transport levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      brk           <= 1'b0;
      ext           <= 1'b0;
      r_held        <= 1'b0;
      kybrd_forward <= 1'b1;
      kybrd_pause   <= 1'b1;
      kybrd_restart <= 1'b0;
    end else begin
      kybrd_restart <= 1'b0;
      if (scan_valid) begin
        if (scan_code == 8'hF0) begin
          brk <= 1'b1;
        end else if (scan_code == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (!ext && !brk) begin
            unique case (scan_code)
              8'h24: kybrd_pause   <= 1'b0;
              8'h23: kybrd_pause   <= 1'b1;
              8'h2B: kybrd_forward <= 1'b1;
              8'h32: kybrd_forward <= 1'b0;
              8'h2D: begin
                if (!r_held)
                  kybrd_restart <= 1'b1;
                r_held <= 1'b1;
              end
              default: ;
            endcase
          end else if (!ext && scan_code == 8'h2D) begin
            r_held <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/ps2_music_commands.md
# ps2_music_commands

Receives PS/2 keyboard frames and turns them into the transport-control levels and pulses that drive `MusicPlayer` (`kybrd_forward`, `kybrd_pause`, plus a restart pulse). It sits directly upstream of `MusicPlayer` on the same `clk`. It synchronises and filters the raw PS/2 lines, deframes 11-bit frames, and tracks make/break/extended prefixes. Only plain make codes are mapped to player commands.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical `ps2_clk` samples needed to change the filtered clock level.
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles without a falling edge, while mid-frame, before the frame is aborted (about 1 ms at 50 MHz).
- `clk`  in  1  system clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock; asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data; asynchronous to `clk`.
- `kybrd_forward`  out  1  level; 1 = play forward, 0 = play backward.
- `kybrd_pause`  out  1  level; 1 = paused.
- `kybrd_restart`  out  1  one-cycle pulse; restart from the beginning of the song.
- `scan_code`  out  8  last correctly received byte; holds its value until the next good frame.
- `scan_valid`  out  1  one-cycle pulse when `scan_code` updates.
- `frame_error`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - Synchronised `ps2_clk` feeds a FILTER_LEN-bit shift register.
  - Filtered clock goes to 0 only when all samples are 0, and to 1 only when all are 1; otherwise it holds.
  - Falling edge = filtered level 1→0; it is a single-cycle strobe.
- **Frame FSM**, states IDLE, DATA, PARITY, STOP; all transitions happen on a falling-edge strobe.
  - IDLE: if sampled data = 0 (start bit), clear the bit count and go to DATA. A start bit of 1 is ignored and the FSM stays in IDLE with no error.
  - DATA: shift in 8 bits, LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the parity bit and go to STOP.
  - STOP: a good frame needs odd parity (XOR of the 8 data bits and the parity bit = 1) and stop bit = 1.
    - Good frame: load `scan_code` and pulse `scan_valid`.
    - Bad frame: pulse `frame_error`.
    - Either way, return to IDLE.
  - Timeout counter:
    - Clears on every falling edge and whenever the FSM is in IDLE.
    - Reaching TIMEOUT_CYCLES in DATA, PARITY or STOP pulses `frame_error` and forces IDLE.
    - If a falling edge and the terminal count fall on the same cycle, the edge wins: the counter clears and the frame continues.
- **Command decoder**, acting on each `scan_valid`:
  - 0xF0 sets `brk`; 0xE0 sets `ext`. Any other code consumes and then clears both flags.
  - Codes with `ext` set are ignored.
  - Make codes (`brk` = 0):
    - 0x24 (E): `kybrd_pause` ← 0.
    - 0x23 (D): `kybrd_pause` ← 1.
    - 0x2B (F): `kybrd_forward` ← 1.
    - 0x32 (B): `kybrd_forward` ← 0.
    - 0x2D (R): pulse `kybrd_restart` only if `r_held` = 0, then set `r_held`.
  - Break of 0x2D (R) clears `r_held`. All other break codes have no effect.
  - Typematic repeats of E/D/F/B rewrite the same level, so they are idempotent. Repeats of R produce no further pulse while `r_held` = 1.
  - Unmapped make codes change nothing except clearing the flags.
  - `frame_error` does not change `brk`, `ext` or `r_held`.

## Timing
- **Reset values:**
  - `kybrd_forward` = 1, `kybrd_pause` = 1, `kybrd_restart` = 0.
  - `scan_code` = 0x00, `scan_valid` = 0, `frame_error` = 0.
  - FSM in IDLE; `brk`, `ext` and `r_held` = 0; filter register and synchronisers all 1s.
- Reset mid-frame discards the partial frame. The first falling edge after reset is treated as a possible start bit.
- Input latency: raw `ps2_clk` fall → filtered edge strobe = 2 (sync) + FILTER_LEN cycles.
- `scan_valid` and `frame_error` assert in the cycle after the stop-bit edge strobe. They are never high together.
- Command outputs (`kybrd_forward`, `kybrd_pause`, `kybrd_restart`) change in the cycle after `scan_valid`.
- `kybrd_restart` is exactly 1 cycle wide.
- Data is sampled with the same synchroniser delay as the clock, so data sampled at the strobe is stable (PS/2 data is held for ≥5 µs around the clock fall).

## Test plan
1. **Reset defaults:** assert `reset` for 3 cycles, then idle lines high → `kybrd_forward` = 1, `kybrd_pause` = 1, no pulses for 10000 cycles.
2. **Good frame and pause control:** send frame 0x24 with parity 1 → `scan_valid` pulse, `scan_code` = 0x24, `kybrd_pause` falls to 0 one cycle later. Send 0x23 → `kybrd_pause` = 1.
3. **Direction and break handling:** send 0x32 → `kybrd_forward` = 0. Send F0, 32 → `kybrd_forward` stays 0. Send 0x2B → `kybrd_forward` = 1. Send E0, 2B → no change.
4. **Restart debounce:** send 2D, 2D, 2D, F0, 2D, 2D → exactly two `kybrd_restart` pulses, each 1 cycle wide.
5. **Frame errors:**
   - 0x24 with wrong parity → `frame_error` pulse, no `scan_valid`, `kybrd_pause` unchanged.
   - Stop bit = 0 → `frame_error`.
   - 4 data bits, then lines held high past TIMEOUT_CYCLES → `frame_error`; a following good 0x23 frame decodes correctly.
6. **Glitch rejection and mid-frame reset:**
   - `ps2_clk` low glitch of FILTER_LEN−1 cycles → no bit sampled.
   - `reset` asserted during DATA → outputs return to their reset values; the next full 0x24 frame decodes.
